// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and constants for the two-port memory arbiter.
//   port_id_t : requester ID (0 = fetch, 1 = LSU)
//   *_NOP     : values driven on the memory side when nothing is selected
package mem_port_arbiter_pkg;
  localparam int ID_W = $clog2(2);
  typedef logic [ID_W-1:0] port_id_t;

  localparam port_id_t   PORT_IF  = 1'b0;
  localparam port_id_t   PORT_LSU = 1'b1;

  localparam logic       WE_NOP   = 1'b0;
  localparam logic [3:0] BE_NOP   = 4'b0000;
endpackage

// File: rtl/mem_port_arbiter_id_fifo.sv
// arb_id_fifo
//   In-order queue of requester IDs for granted-but-not-returned transactions.
//   Ports: clk, reset (sync, active-high)
//          push_i/din_i : enqueue an ID on grant
//          pop_i        : dequeue the head on response (caller guarantees ~empty)
//          head_o       : ID of the oldest outstanding transaction
//          full_o, empty_o, count_o : occupancy
module arb_id_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  port_id_t         din_i,
  input  logic             pop_i,
  output port_id_t         head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  port_id_t         mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;   // push+pop keeps occupancy, head still moves
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // ID storage needs no reset: entries are only read while count_q != 0
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one req/gnt/rvalid memory port between fetch (m0) and LSU (m1).
//   Grant and response paths are combinational; issue order is tracked in
//   an ID FIFO so each rvalid is steered back to its originator.
//   Ports: clk, reset (sync, active-high)
//          m0_*/m1_* : requester side (req/addr/we/be/wdata in, gnt/rvalid out)
//          m_rdata   : response data broadcast to both requesters
//          mem_*     : memory side
//          arb_idle  : nothing outstanding, no lock, no request pending
//          arb_err   : sticky, rvalid seen with nothing outstanding
//   Build option: define ARB_ROUND_ROBIN_EN for round-robin contention;
//   otherwise the LSU wins every contention.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m0_req,
  input  logic [XLEN-1:0] m0_addr,
  input  logic            m0_we,
  input  logic [3:0]      m0_be,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic            m1_req,
  input  logic [XLEN-1:0] m1_addr,
  input  logic            m1_we,
  input  logic [3:0]      m1_be,
  input  logic [XLEN-1:0] m1_wdata,
  output logic            m0_gnt,
  output logic            m1_gnt,
  output logic            m0_rvalid,
  output logic            m1_rvalid,
  output logic [XLEN-1:0] m_rdata,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            arb_idle,
  output logic            arb_err
);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic             lock_q, lock_d;
  port_id_t         lock_id_q, lock_id_d;
  port_id_t         last_q, last_d;
  logic             err_q, err_d;
  port_id_t         owner, contend_id, head;
  logic             owner_req, grant, pop, full, empty;
  logic [CNT_W-1:0] count;

`ifdef ARB_ROUND_ROBIN_EN
  assign contend_id = ~last_q;
`else
  assign contend_id = PORT_LSU;
`endif

  // A locked owner keeps the port until granted so the memory side sees a
  // stable request.
  always_comb begin
    owner = PORT_IF;
    if (lock_q)                owner = lock_id_q;
    else if (m0_req && m1_req) owner = contend_id;
    else if (m1_req)           owner = PORT_LSU;
  end

  assign owner_req = (owner == PORT_LSU) ? m1_req : m0_req;
  assign mem_req   = owner_req & ~full;
  assign grant     = mem_req & mem_gnt;
  assign m0_gnt    = grant & (owner == PORT_IF);
  assign m1_gnt    = grant & (owner == PORT_LSU);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = WE_NOP;
    mem_be    = BE_NOP;
    if (owner_req) begin
      if (owner == PORT_LSU) begin
        mem_addr = m1_addr; mem_wdata = m1_wdata; mem_we = m1_we; mem_be = m1_be;
      end else begin
        mem_addr = m0_addr; mem_wdata = m0_wdata; mem_we = m0_we; mem_be = m0_be;
      end
    end
  end

  assign pop       = mem_rvalid & ~empty;
  assign m0_rvalid = pop & (head == PORT_IF);
  assign m1_rvalid = pop & (head == PORT_LSU);
  assign m_rdata   = mem_rdata;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (mem_req && !mem_gnt) begin
      lock_d    = 1'b1;
      lock_id_d = owner;
    end else if (grant) begin
      lock_d    = 1'b0;
    end
    last_d = grant ? owner : last_q;
    err_d  = err_q | (mem_rvalid & empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q    <= 1'b0;
      lock_id_q <= PORT_IF;
      last_q    <= PORT_LSU;
      err_q     <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

  arb_id_fifo #(.DEPTH(MAX_OUTST), .CNT_W(CNT_W)) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (grant),
    .din_i   (owner),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // Idle means the outstanding count has drained as well as no lock/request.
  assign arb_idle = (count == '0) & ~lock_q & ~m0_req & ~m1_req;
  assign arb_err  = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic        clk = 1'b0, reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be, mem_be;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, arb_idle, arb_err;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(32), .MAX_OUTST(2)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m_rdata(m_rdata), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .arb_idle(arb_idle), .arb_err(arb_err));

  // inputs change 1 time unit after posedge; outputs sampled 3 units later
  task automatic step(); @(posedge clk); #1; endtask
  task automatic settle(); #3; endtask

  task automatic test_reset();
    reset = 1'b1; m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0; m0_be = 0; m1_be = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    step(); step(); reset = 1'b0; settle();
    total++; if (arb_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", arb_idle); end
    total++; if (arb_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", arb_err); end
    total++; if ({mem_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 5'b0) begin bad++;
      $display("FAIL reset_outs got=%b exp=00000", {mem_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}); end
    total++; if ({mem_addr, mem_we, mem_be} !== 37'h0) begin bad++;
      $display("FAIL reset_mux got=%h exp=0", {mem_addr, mem_we, mem_be}); end
  endtask

  task automatic test_single_fetch();
    step();
    m0_req = 1; m0_addr = 32'h100; m0_be = 4'hF; mem_gnt = 1; settle();
    total++; if ({m0_gnt, m1_gnt, mem_req} !== 3'b101) begin bad++;
      $display("FAIL fetch_gnt got=%b exp=101", {m0_gnt, m1_gnt, mem_req}); end
    total++; if ({mem_addr, mem_be} !== {32'h100, 4'hF}) begin bad++;
      $display("FAIL fetch_addr got=%h exp=100f", {mem_addr, mem_be}); end
    step();
    m0_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013; settle();
    total++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin bad++;
      $display("FAIL fetch_rvalid got=%b exp=10", {m0_rvalid, m1_rvalid}); end
    total++; if (m_rdata !== 32'h13) begin bad++; $display("FAIL fetch_rdata got=%h exp=13", m_rdata); end
    step();
    mem_rvalid = 0; settle();
    total++; if ({arb_idle, arb_err, m0_rvalid} !== 3'b100) begin bad++;
      $display("FAIL fetch_after got=%b exp=100", {arb_idle, arb_err, m0_rvalid}); end
  endtask

  task automatic test_contention();
    m0_req = 1; m0_addr = 32'h200; m1_req = 1; m1_addr = 32'h300; m1_we = 1; m1_wdata = 32'hCAFE;
    mem_gnt = 1; settle();
    total++; if ({m0_gnt, m1_gnt} !== 2'b01) begin bad++; $display("FAIL cont_first got=%b exp=01", {m0_gnt, m1_gnt}); end
    total++; if ({mem_addr, mem_we, mem_wdata} !== {32'h300, 1'b1, 32'hCAFE}) begin bad++;
      $display("FAIL cont_mux1 got=%h/%b/%h exp=300/1/cafe", mem_addr, mem_we, mem_wdata); end
    step();
    m1_req = 0; m1_we = 0; settle();
    total++; if ({m0_gnt, m1_gnt, mem_addr} !== {2'b10, 32'h200}) begin bad++;
      $display("FAIL cont_second got=%b/%h exp=10/200", {m0_gnt, m1_gnt}, mem_addr); end
    step();
    m0_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hAA; settle();
    total++; if ({m0_rvalid, m1_rvalid} !== 2'b01) begin bad++; $display("FAIL cont_ret1 got=%b exp=01", {m0_rvalid, m1_rvalid}); end
    step();
    mem_rdata = 32'hBB; settle();
    total++; if ({m0_rvalid, m1_rvalid, m_rdata} !== {2'b10, 32'hBB}) begin bad++;
      $display("FAIL cont_ret2 got=%b/%h exp=10/bb", {m0_rvalid, m1_rvalid}, m_rdata); end
    step();
    mem_rvalid = 0; settle();
    total++; if (arb_idle !== 1'b1) begin bad++; $display("FAIL cont_idle got=%b exp=1", arb_idle); end
  endtask

  task automatic test_lock();
    m0_req = 1; m0_addr = 32'h400; mem_gnt = 0; settle();
    total++; if ({mem_req, m0_gnt, mem_addr} !== {2'b10, 32'h400}) begin bad++;
      $display("FAIL lock_c0 got=%b/%h exp=10/400", {mem_req, m0_gnt}, mem_addr); end
    step();
    m1_req = 1; m1_addr = 32'h500; settle();
    total++; if ({mem_req, m1_gnt, mem_addr} !== {2'b10, 32'h400}) begin bad++;
      $display("FAIL lock_c1 got=%b/%h exp=10/400", {mem_req, m1_gnt}, mem_addr); end
    step(); settle();
    total++; if ({mem_addr, arb_idle} !== {32'h400, 1'b0}) begin bad++;
      $display("FAIL lock_c2 got=%h/%b exp=400/0", mem_addr, arb_idle); end
    step();
    mem_gnt = 1; settle();
    total++; if ({m0_gnt, m1_gnt, mem_addr} !== {2'b10, 32'h400}) begin bad++;
      $display("FAIL lock_gnt got=%b/%h exp=10/400", {m0_gnt, m1_gnt}, mem_addr); end
    step();
    m0_req = 0; settle();
    total++; if ({m0_gnt, m1_gnt, mem_addr} !== {2'b01, 32'h500}) begin bad++;
      $display("FAIL lock_lsu got=%b/%h exp=01/500", {m0_gnt, m1_gnt}, mem_addr); end
    step();
    m1_req = 0; mem_gnt = 0; mem_rvalid = 1; settle();
    total++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin bad++; $display("FAIL lock_ret1 got=%b exp=10", {m0_rvalid, m1_rvalid}); end
    step(); settle();
    total++; if ({m0_rvalid, m1_rvalid} !== 2'b01) begin bad++; $display("FAIL lock_ret2 got=%b exp=01", {m0_rvalid, m1_rvalid}); end
    step();
    mem_rvalid = 0;
  endtask

  task automatic test_back_to_back();
    // cycle 0: fetch granted
    m0_req = 1; m0_addr = 32'h600; mem_gnt = 1; settle();
    total++; if (m0_gnt !== 1'b1) begin bad++; $display("FAIL b2b_g0 got=%b exp=1", m0_gnt); end
    step();
    // cycle 1: LSU granted, FIFO becomes full
    m0_req = 0; m1_req = 1; m1_addr = 32'h680; settle();
    total++; if (m1_gnt !== 1'b1) begin bad++; $display("FAIL b2b_g1 got=%b exp=1", m1_gnt); end
    step();
    // cycle 2: third request held off even though this cycle pops
    m1_req = 0; m0_req = 1; m0_addr = 32'h700; mem_rvalid = 1; mem_rdata = 32'h11; settle();
    total++; if ({mem_req, m0_gnt, m0_rvalid, m1_rvalid} !== 4'b0010) begin bad++;
      $display("FAIL b2b_full got=%b exp=0010", {mem_req, m0_gnt, m0_rvalid, m1_rvalid}); end
    step();
    // cycle 3: push and pop together
    mem_rdata = 32'h22; settle();
    total++; if ({mem_req, m0_gnt, m0_rvalid, m1_rvalid} !== 4'b1101) begin bad++;
      $display("FAIL b2b_pushpop got=%b exp=1101", {mem_req, m0_gnt, m0_rvalid, m1_rvalid}); end
    step();
    m0_req = 0; mem_gnt = 0; mem_rvalid = 0; settle();
    total++; if (arb_idle !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b exp=0", arb_idle); end
    step();
    mem_rvalid = 1; mem_rdata = 32'h33; settle();
    total++; if ({m0_rvalid, m1_rvalid, m_rdata} !== {2'b10, 32'h33}) begin bad++;
      $display("FAIL b2b_ret3 got=%b/%h exp=10/33", {m0_rvalid, m1_rvalid}, m_rdata); end
    step();
    mem_rvalid = 0; settle();
    total++; if ({arb_idle, arb_err} !== 2'b10) begin bad++; $display("FAIL b2b_end got=%b exp=10", {arb_idle, arb_err}); end
  endtask

  task automatic test_spurious();
    mem_rvalid = 1; mem_rdata = 32'hDEAD; settle();
    total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin bad++; $display("FAIL spur_drop got=%b exp=00", {m0_rvalid, m1_rvalid}); end
    step();
    mem_rvalid = 0; settle();
    total++; if (arb_err !== 1'b1) begin bad++; $display("FAIL spur_set got=%b exp=1", arb_err); end
    step(); step(); settle();
    total++; if (arb_err !== 1'b1) begin bad++; $display("FAIL spur_sticky got=%b exp=1", arb_err); end
    reset = 1; step(); reset = 0; settle();
    total++; if ({arb_err, arb_idle} !== 2'b01) begin bad++; $display("FAIL spur_clear got=%b exp=01", {arb_err, arb_idle}); end
    // reset with a transaction outstanding drops its ID
    step();
    m0_req = 1; m0_addr = 32'h800; mem_gnt = 1; step();
    m0_req = 0; mem_gnt = 0; reset = 1; step();
    reset = 0; mem_rvalid = 1; settle();
    total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin bad++; $display("FAIL late_drop got=%b exp=00", {m0_rvalid, m1_rvalid}); end
    step();
    mem_rvalid = 0; settle();
    total++; if (arb_err !== 1'b1) begin bad++; $display("FAIL late_err got=%b exp=1", arb_err); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_lock();
    test_back_to_back();
    test_spurious();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing one instruction/data memory port between the fetch unit (port 0) and the load/store unit (port 1). Both requester sides and the memory side use the same req/gnt/rvalid protocol as the core's memory interface. The block tracks outstanding transactions in issue order and routes each `rvalid`/`rdata` back to its originator. It sits between the core's memory clients and the single memory macro or bus port.

## Interface
Parameters:
- `XLEN`, 32, address/data width.
- `MAX_OUTST`, 2, maximum granted-but-not-returned transactions (1..4).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `m0_req`, `m1_req`  in  1  request from fetch / LSU.
- `m0_addr`, `m1_addr`  in  XLEN  word address.
- `m0_we`, `m1_we`  in  1  write enable (fetch ties to 0).
- `m0_be`, `m1_be`  in  4  byte enables.
- `m0_wdata`, `m1_wdata`  in  XLEN  write data.
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle.
- `m0_rvalid`, `m1_rvalid`  out  1  response for this requester.
- `m_rdata`  out  XLEN  response data, broadcast to both requesters.
- `mem_req`  out  1  request to memory.
- `mem_addr`, `mem_wdata`  out  XLEN  muxed from the selected requester.
- `mem_we`  out  1  muxed from the selected requester.
- `mem_be`  out  4  muxed from the selected requester.
- `mem_gnt`, `mem_rvalid`  in  1  memory handshake.
- `mem_rdata`  in  XLEN  memory read data.
- `arb_idle`  out  1  no outstanding and no locked request; allows a safe core reset/flush.
- `arb_err`  out  1  sticky; set when `rvalid` arrives with nothing outstanding.

## Operation
- **Owner select (comb)**
  - If `lock_q` is set, owner = `lock_id_q`.
  - Otherwise, only one `req` high: that requester is owner.
  - Otherwise, both high: apply the arbitration policy (see Configuration).
- **Memory request**
  - `mem_req = owner_req & ~full`.
  - `mem_addr`, `mem_we`, `mem_be`, `mem_wdata` come from the owner. They are 0 when no `req` is high.
- **Grant**
  - `mX_gnt = mem_gnt & mem_req & (owner==X)`.
  - A non-owner never sees `gnt`.
- **Lock**
  - When `mem_req & ~mem_gnt`: `lock_q<=1` and `lock_id_q<=owner`.
  - Lock clears on the cycle `mem_gnt` is seen.
  - This keeps the memory-side address stable until grant.
- **ID FIFO**
  - On each grant, push owner ID.
  - `mX_rvalid = mem_rvalid & ~empty & (head==X)`.
  - Pop on `mem_rvalid` when not empty.
  - Push and pop in the same cycle are allowed: count stays the same, and head advances.
- **Full**
  - When `count==MAX_OUTST`, `mem_req` is forced to 0, even if `mem_rvalid` pops the same cycle.
- **Error**
  - `mem_rvalid` while empty: response dropped (no `mX_rvalid`), `arb_err<=1`.
  - `arb_err` is cleared only by `reset`.
- `arb_idle = empty & ~lock_q & ~m0_req & ~m1_req`.

## Timing
- Grant path is combinational: a request can be granted in its request cycle, with zero added latency.
- Response path is combinational: `mem_rvalid` → `mX_rvalid` in the same cycle, and `m_rdata = mem_rdata`.
- Requesters hold `req`, `addr`, `we`, `be` and `wdata` until `gnt`. The arbiter never de-asserts `mem_req` for a locked owner before `gnt`, except when full.
- Responses return in grant order; memory is in-order.
- Reset values:
  - FIFO empty, `lock_q=0`, `last_q=1`, `arb_err=0`.
  - All registered-derived outputs are 0.
  - `arb_idle=1` if no `req`.
- Reset mid-transaction discards outstanding IDs. Any late `mem_rvalid` after reset sets `arb_err`.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - On contention, grant the requester opposite to `last_q`.
  - `last_q` updates to the granted ID on each grant.
- Not defined:
  - Fixed priority: port 1 (LSU) wins every contention.
  - `last_q` is still present but unused. Starvation of fetch is permitted; the core guarantees LSU gaps.

## Structure
- Shared package: ID width (`$clog2(2)`), port ID constants `PORT_IF=0` and `PORT_LSU=1`, and the NOP/default constants.
- One sub-module, `arb_id_fifo`:
  - Depth `MAX_OUTST`, width 1.
  - Interface: push, pop, head, full, empty, count.
- The top module holds owner select, lock, muxing and the error flag.

## Test plan
- **Single fetch:** `m0_req`, addr `0x100`, `mem_gnt=1` same cycle, `rvalid` 1 cycle later with data `0x00000013` → `m0_gnt` in cycle 0, `m0_rvalid` + data in cycle 1, `m1_rvalid` stays 0.
- **Contention, fixed priority:** both `req` in the same cycle, `mem_gnt=1` → `m1_gnt` first, `m0_gnt` next cycle. With `ARB_ROUND_ROBIN_EN`, the grants alternate 0,1,0,1 over 4 back-to-back pairs.
- **Lock:** `m0_req` with `mem_gnt=0` for 3 cycles, `m1_req` rises in cycle 1 → `mem_addr` stays `m0_addr` until `gnt`. Then the LSU is granted.
- **Interleaved returns, `MAX_OUTST=2`:** grant m0 then m1, rvalids 2 and 3 cycles later → `m0_rvalid` then `m1_rvalid`. A third request is held off (`mem_req=0`) until the first pop.
- **Spurious `rvalid` with empty FIFO:** → no `mX_rvalid`, `arb_err=1` and it stays 1. `reset` clears it and `arb_idle=1`.
